// File: rtl/ysyx_25040129_axi_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_axi_arbiter_pkg
// Shared definitions for the two-master AXI4 arbiter:
//   - arb_state_e : arbiter state encoding (IDLE / IFU_R / LSU_R / LSU_W)
//   - AXI_RESP_*  : AXI response codes
//   - AXI_BURST_* : AXI burst type codes
//   - GRANT_*     : encoding of the round-robin last-grant bit
// ----------------------------------------------------------------------------
package ysyx_25040129_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IFU_R = 2'b01,
        ST_LSU_R = 2'b10,
        ST_LSU_W = 2'b11
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Meaning of the last_grant bit when round-robin is enabled.
    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25040129_axi_arbiter_pick.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_arb_pick
// Combinational picker: chooses which state the arbiter enters from IDLE.
// Configuration macro: YSYX_25040129_ARB_RR_EN
//   defined   -> round-robin between IFU and LSU using last_grant
//   undefined -> fixed priority LSU write > LSU read > IFU read
// Within the LSU a write always beats a read.
// Ports:
//   ifu_req     in  IFU read address valid
//   lsu_ar_req  in  LSU read address valid
//   lsu_aw_req  in  LSU write address valid
//   last_grant  in  master granted most recently (GRANT_IFU / GRANT_LSU)
//   next_state  out state to enter (ST_IDLE when nobody requests)
// ----------------------------------------------------------------------------
module ysyx_25040129_arb_pick
    import ysyx_25040129_axi_arbiter_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_ar_req,
    input  logic       lsu_aw_req,
    input  logic       last_grant,
    output arb_state_e next_state
);

    arb_state_e lsu_pick;

    // The LSU's own choice, write first.
    always_comb begin
        lsu_pick = ST_IDLE;
        if (lsu_aw_req) begin
            lsu_pick = ST_LSU_W;
        end else if (lsu_ar_req) begin
            lsu_pick = ST_LSU_R;
        end
    end

`ifdef YSYX_25040129_ARB_RR_EN
    always_comb begin
        next_state = ST_IDLE;
        if (ifu_req && (lsu_pick != ST_IDLE)) begin
            // Conflict: the master that was not granted last time wins.
            next_state = (last_grant == GRANT_LSU) ? ST_IFU_R : lsu_pick;
        end else if (lsu_pick != ST_IDLE) begin
            next_state = lsu_pick;
        end else if (ifu_req) begin
            next_state = ST_IFU_R;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        next_state = ST_IDLE;
        if (lsu_pick != ST_IDLE) begin
            next_state = lsu_pick;
        end else if (ifu_req) begin
            next_state = ST_IFU_R;
        end
    end
`endif

endmodule

// File: rtl/ysyx_25040129_axi_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_axi_arbiter
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// Exactly one transaction is in flight; the grant is held until the final
// response handshake (R with rlast, or B). Granted channels are wired through
// combinationally; every other output is 0. Arbitration costs one cycle.
// Configuration macro: YSYX_25040129_ARB_RR_EN (round-robin IFU/LSU).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifu_ar*, ifu_r*                    IFU read address / read data
//   lsu_ar*, lsu_r*                    LSU read address / read data
//   lsu_aw*, lsu_w*, lsu_b*            LSU write address / data / response
//   ar*, r*, aw*, w*, b* (no prefix)   downstream master port to the crossbar
// ----------------------------------------------------------------------------
module ysyx_25040129_axi_arbiter
    import ysyx_25040129_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // IFU read
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    input  logic [2:0]          ifu_arsize,
    input  logic [7:0]          ifu_arlen,
    input  logic [1:0]          ifu_arburst,
    input  logic [ADDR_W-1:0]   ifu_arsatp,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    output logic                ifu_rlast,
    input  logic                ifu_rready,
    // LSU read
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    input  logic [2:0]          lsu_arsize,
    input  logic [7:0]          lsu_arlen,
    input  logic [1:0]          lsu_arburst,
    input  logic [ADDR_W-1:0]   lsu_arsatp,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    output logic                lsu_rlast,
    input  logic                lsu_rready,
    // LSU write
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awsatp,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    // Downstream
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    output logic [2:0]          arsize,
    output logic [7:0]          arlen,
    output logic [1:0]          arburst,
    output logic [ADDR_W-1:0]   arsatp,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    input  logic                rlast,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awsatp,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    arb_state_e state_q, state_d;
    arb_state_e pick_state;
    logic       last_grant;

    ysyx_25040129_arb_pick u_pick (
        .ifu_req    (ifu_arvalid),
        .lsu_ar_req (lsu_arvalid),
        .lsu_aw_req (lsu_awvalid),
        .last_grant (last_grant),
        .next_state (pick_state)
    );

`ifdef YSYX_25040129_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if ((state_q == ST_IDLE) && (pick_state != ST_IDLE)) begin
            last_grant_d = (pick_state == ST_IFU_R) ? GRANT_IFU : GRANT_LSU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GRANT_IFU;
`endif

    // State register. Reset is asynchronous so every output (all decoded from
    // state_q) drops to 0 the moment rst_n falls, even mid-burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: exit only on the final response handshake of the owner;
    // valid dropping mid-transaction does not release the grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = pick_state;
            ST_IFU_R: if (rvalid && ifu_rready && rlast) state_d = ST_IDLE;
            ST_LSU_R: if (rvalid && lsu_rready && rlast) state_d = ST_IDLE;
            ST_LSU_W: if (bvalid && lsu_bready)          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output routing: everything defaults to 0, the owner's channels are
    // passed through combinationally.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        ifu_rlast   = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_rlast   = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        araddr      = '0;
        arvalid     = 1'b0;
        arsize      = '0;
        arlen       = '0;
        arburst     = '0;
        arsatp      = '0;
        rready      = 1'b0;
        awaddr      = '0;
        awvalid     = 1'b0;
        awsatp      = '0;
        wstrb       = '0;
        wdata       = '0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (state_q)
            ST_IFU_R: begin
                araddr      = ifu_araddr;
                arvalid     = ifu_arvalid;
                arsize      = ifu_arsize;
                arlen       = ifu_arlen;
                arburst     = ifu_arburst;
                arsatp      = ifu_arsatp;
                ifu_arready = arready;
                ifu_rdata   = rdata;
                ifu_rresp   = rresp;
                ifu_rvalid  = rvalid;
                ifu_rlast   = rlast;
                rready      = ifu_rready;
            end
            ST_LSU_R: begin
                araddr      = lsu_araddr;
                arvalid     = lsu_arvalid;
                arsize      = lsu_arsize;
                arlen       = lsu_arlen;
                arburst     = lsu_arburst;
                arsatp      = lsu_arsatp;
                lsu_arready = arready;
                lsu_rdata   = rdata;
                lsu_rresp   = rresp;
                lsu_rvalid  = rvalid;
                lsu_rlast   = rlast;
                rready      = lsu_rready;
            end
            ST_LSU_W: begin
                awaddr      = lsu_awaddr;
                awvalid     = lsu_awvalid;
                awsatp      = lsu_awsatp;
                lsu_awready = awready;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                wvalid      = lsu_wvalid;
                lsu_wready  = wready;
                lsu_bresp   = bresp;
                lsu_bvalid  = bvalid;
                bready      = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
module tb_ysyx_25040129_axi_arbiter;
    import ysyx_25040129_axi_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ifu_araddr, ifu_arsatp, lsu_araddr, lsu_arsatp;
    logic        ifu_arvalid, lsu_arvalid;
    logic [2:0]  ifu_arsize, lsu_arsize;
    logic [7:0]  ifu_arlen, lsu_arlen;
    logic [1:0]  ifu_arburst, lsu_arburst;
    logic        ifu_arready, lsu_arready;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic [1:0]  ifu_rresp, lsu_rresp;
    logic        ifu_rvalid, ifu_rlast, ifu_rready;
    logic        lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_awaddr, lsu_awsatp, lsu_wdata;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] araddr, arsatp, rdata, awaddr, awsatp, wdata;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst, rresp, bresp;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_25040129_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arsize(ifu_arsize),
        .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst), .ifu_arsatp(ifu_arsatp),
        .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rvalid(ifu_rvalid), .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arsize(lsu_arsize),
        .lsu_arlen(lsu_arlen), .lsu_arburst(lsu_arburst), .lsu_arsatp(lsu_arsatp),
        .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rvalid(lsu_rvalid), .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awsatp(lsu_awsatp),
        .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .araddr(araddr), .arvalid(arvalid), .arsize(arsize), .arlen(arlen),
        .arburst(arburst), .arsatp(arsatp), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awsatp(awsatp),
        .wstrb(wstrb), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // OR of every output so "all outputs are 0" is one comparison.
    function automatic logic any_out();
        return ifu_arready | ifu_rvalid | ifu_rlast | (|ifu_rdata) | (|ifu_rresp) |
               lsu_arready | lsu_rvalid | lsu_rlast | (|lsu_rdata) | (|lsu_rresp) |
               lsu_awready | lsu_wready | lsu_bvalid | (|lsu_bresp) |
               (|araddr) | arvalid | (|arsize) | (|arlen) | (|arburst) | (|arsatp) |
               rready | (|awaddr) | awvalid | (|awsatp) | (|wstrb) | (|wdata) |
               wvalid | bready;
    endfunction

    task automatic clear_inputs();
        ifu_araddr = 0; ifu_arvalid = 0; ifu_arsize = 0; ifu_arlen = 0;
        ifu_arburst = 0; ifu_arsatp = 0; ifu_rready = 0;
        lsu_araddr = 0; lsu_arvalid = 0; lsu_arsize = 0; lsu_arlen = 0;
        lsu_arburst = 0; lsu_arsatp = 0; lsu_rready = 0;
        lsu_awaddr = 0; lsu_awvalid = 0; lsu_awsatp = 0; lsu_wdata = 0;
        lsu_wstrb = 0; lsu_wvalid = 0; lsu_bready = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0; rlast = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Drive nonzero inputs during reset: outputs must still be 0.
        ifu_arvalid = 1; ifu_araddr = 32'h1234_5678; rvalid = 1; rdata = 32'hFFFF_FFFF;
        bvalid = 1; arready = 1;
        step(); step();
        chk("reset_all_zero", 64'(any_out()), 64'd0);
        clear_inputs();
        step();
        rst_n = 1'b1;
        step();

        // ---------------- IFU-only 4-beat burst ----------------
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd3;
        ifu_arsize = 3'd2; ifu_arburst = AXI_BURST_INCR; ifu_arsatp = 32'h8000_0001;
        arready = 1; ifu_rready = 1;
        settle();
        chk("ifu_req_idle_arvalid", 64'(arvalid), 64'd0);
        step();
        settle();
        chk("ifu_grant_arvalid", 64'(arvalid), 64'd1);
        chk("ifu_grant_araddr", 64'(araddr), 64'h3000_0000);
        chk("ifu_grant_arlen", 64'(arlen), 64'd3);
        chk("ifu_grant_arsatp", 64'(arsatp), 64'h8000_0001);
        chk("ifu_arready", 64'(ifu_arready), 64'd1);
        step();
        ifu_arvalid = 0; arready = 0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1; rdata = 32'hA000_0000 + 32'(b); rlast = (b == 3); rresp = AXI_RESP_OKAY;
            settle();
            chk($sformatf("ifu_beat%0d_rdata", b), 64'(ifu_rdata), 64'hA000_0000 + 64'(b));
            chk($sformatf("ifu_beat%0d_rlast", b), 64'(ifu_rlast), (b == 3) ? 64'd1 : 64'd0);
            chk($sformatf("ifu_beat%0d_lsu_rvalid", b), 64'(lsu_rvalid), 64'd0);
            step();
        end
        rvalid = 0; rlast = 0;
        settle();
        chk("ifu_done_idle_rready", 64'(rready), 64'd0);
        ifu_rready = 0;
        step();

        // ---------------- Conflict: LSU read vs IFU read ----------------
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0100; ifu_arlen = 0;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0200; lsu_arlen = 0;
        arready = 1; ifu_rready = 1; lsu_rready = 1;
        step();
        settle();
        chk("conflict1_araddr_lsu", 64'(araddr), 64'h8000_0200);
        chk("conflict1_ifu_arready", 64'(ifu_arready), 64'd0);
        chk("conflict1_lsu_arready", 64'(lsu_arready), 64'd1);
        step();
        lsu_arvalid = 0;
        rvalid = 1; rlast = 1; rdata = 32'h5555_AAAA;
        settle();
        chk("conflict1_lsu_rdata", 64'(lsu_rdata), 64'h5555_AAAA);
        chk("conflict1_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
        step();
        rvalid = 0; rlast = 0;
        settle();
        chk("conflict1_m1_idle", 64'(arvalid), 64'd0);
        step();
        settle();
        chk("conflict1_m2_ifu_araddr", 64'(araddr), 64'h3000_0100);
        chk("conflict1_m2_ifu_arready", 64'(ifu_arready), 64'd1);
        step();
        ifu_arvalid = 0;
        rvalid = 1; rlast = 1;
        step();
        rvalid = 0; rlast = 0;
        step();

        // ---------------- Second conflict: last grant was IFU ----------------
        // Both schemes pick LSU here (fixed priority, or IFU granted last).
        ifu_arvalid = 1; lsu_arvalid = 1;
        step();
        settle();
        chk("conflict2_araddr", 64'(araddr), 64'h8000_0200);
        step();
        lsu_arvalid = 0;
        rvalid = 1; rlast = 1;
        step();
        rvalid = 0; rlast = 0;
        lsu_arvalid = 1;            // re-request together with the held IFU
        step();
        settle();
`ifdef YSYX_25040129_ARB_RR_EN
        chk("conflict3_rr_ifu_wins", 64'(araddr), 64'h3000_0100);
`else
        chk("conflict3_fixed_lsu_wins", 64'(araddr), 64'h8000_0200);
`endif
        step();
        ifu_arvalid = 0; lsu_arvalid = 0;
        rvalid = 1; rlast = 1;
        step();
        rvalid = 0; rlast = 0;
        ifu_arvalid = 1;            // whichever lost gets served now
        lsu_arvalid = 0;
`ifdef YSYX_25040129_ARB_RR_EN
        ifu_arvalid = 0; lsu_arvalid = 1;
`endif
        step();
        settle();
        ifu_arvalid = 0; lsu_arvalid = 0;
        step();
        rvalid = 1; rlast = 1;
        step();
        rvalid = 0; rlast = 0;
        step();

        // ---------------- LSU store (with a read requested too) ----------------
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010; lsu_awsatp = 32'h0000_0042;
        lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0300;
        awready = 1; wready = 1; arready = 1;
        step();
        settle();
        chk("store_awvalid", 64'(awvalid), 64'd1);
        chk("store_awaddr", 64'(awaddr), 64'h8000_0010);
        chk("store_awsatp", 64'(awsatp), 64'h42);
        chk("store_wdata", 64'(wdata), 64'hDEAD_BEEF);
        chk("store_wstrb", 64'(wstrb), 64'hF);
        chk("store_arvalid", 64'(arvalid), 64'd0);
        chk("store_lsu_arready", 64'(lsu_arready), 64'd0);
        chk("store_lsu_awready", 64'(lsu_awready), 64'd1);
        chk("store_lsu_wready", 64'(lsu_wready), 64'd1);
        step();
        lsu_awvalid = 0; lsu_wvalid = 0;
        bvalid = 1; bresp = AXI_RESP_SLVERR; lsu_bready = 0;
        settle();
        chk("store_lsu_bvalid", 64'(lsu_bvalid), 64'd1);
        chk("store_lsu_bresp", 64'(lsu_bresp), 64'(AXI_RESP_SLVERR));
        chk("store_bready_low", 64'(bready), 64'd0);
        step();
        lsu_bready = 1;
        settle();
        chk("store_still_granted", 64'(lsu_bvalid), 64'd1);
        chk("store_bready_high", 64'(bready), 64'd1);
        step();
        bvalid = 0; lsu_bready = 0;
        settle();
        chk("store_done_idle", 64'(arvalid), 64'd0);
        step();
        settle();
        chk("after_store_lsu_read", 64'(araddr), 64'h8000_0300);

        // ---------------- Backpressure on final beat ----------------
        step();
        lsu_arvalid = 0;
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0400; ifu_arlen = 8'd3;
        rvalid = 1; rlast = 1; rdata = 32'h0BAD_F00D; lsu_rready = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("bp%0d_ifu_arready", c), 64'(ifu_arready), 64'd0);
            chk($sformatf("bp%0d_lsu_rvalid", c), 64'(lsu_rvalid), 64'd1);
            step();
        end
        lsu_rready = 1;
        step();
        rvalid = 0; rlast = 0; lsu_rready = 0;
        step();
        settle();
        chk("bp_then_ifu_grant", 64'(araddr), 64'h3000_0400);

        // ---------------- Async reset mid-burst ----------------
        step();
        ifu_arvalid = 0;
        rvalid = 1; rlast = 0; rdata = 32'hB000_0000; ifu_rready = 1;
        step();                     // beat 1 accepted
        rdata = 32'hB000_0001;
        settle();
        chk("rst_beat2_before", 64'(ifu_rdata), 64'hB000_0001);
        rst_n = 1'b0;
        #1;
        chk("rst_async_all_zero", 64'(any_out()), 64'd0);
        step();
        rvalid = 0;
        rst_n = 1'b1;
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0800;
        settle();
        chk("post_rst_idle", 64'(arvalid), 64'd0);
        step();
        settle();
        chk("post_rst_grant_arvalid", 64'(arvalid), 64'd1);
        chk("post_rst_grant_araddr", 64'(araddr), 64'h3000_0800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
